// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcode values, ALU-control operation codes and trap cause codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Opcode field values
  localparam logic [5:0] R_Type = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;

  // Codes understood by the existing ALU control block
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_NOP   = 3'b010;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // State following DECODE for a given opcode; unknown opcodes trap.
  function automatic state_t decode_op(input logic [5:0] op);
    state_t nxt;
    case (op)
      R_Type:               nxt = EXEC_R;
      ADDI, ORI, ANDI, LUI: nxt = EXEC_I;
      LW, SW:               nxt = MEM_ADDR;
      BEQ, BNE:             nxt = BRANCH;
      J, JAL:               nxt = JUMP;
      default:              nxt = TRAP;
    endcase
    return nxt;
  endfunction

  // ALU operation for the immediate-format arithmetic/logic instructions.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      ORI:     code = ALU_OR;
      ANDI:    code = ALU_AND;
      LUI:     code = ALU_LUI;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts cycles spent waiting for memory in a memory-access state and flags
// a timeout once the count reaches MEM_TIMEOUT. The count saturates.
module mem_wait_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear on a state change, otherwise count stalled cycles up to saturation.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wait_i && !ready_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (MEM_TIMEOUT != 0) && wait_i && (count_q == CNT_LIM);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/write-back, handles
// memory-ready stalls with a watchdog, and halts in TRAP on illegal opcodes
// or memory timeouts until reset.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    OP,
  input  logic                   mem_ready,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   BranchType,
  output logic [1:0]             PCSource,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   RegWrite,
  output logic [3:0]             state,
  output logic                   trap,
  output logic [1:0]             trap_cause
);

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [1:0]          cause_q, cause_d;
  logic                in_wait, wd_clear, timeout;
  logic [2:0]          alu_op;
  logic [5:0]          op_in, op_cur;

  assign op_in    = 6'(OP);
  assign op_cur   = 6'(op_q);
  assign in_wait  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign wd_clear = (state_d != state_q);

  mem_wait_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .wait_i   (in_wait),
    .ready_i  (mem_ready),
    .clear_i  (wd_clear),
    .timeout_o(timeout)
  );

  // State, captured opcode and sticky trap cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic and per-state datapath strobes; all strobes forced low in reset.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cause_d     = cause_q;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchType  = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    alu_op      = 3'b000;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;

    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        alu_op  = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          MemRead = 1'b0;
          state_d = TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        alu_op  = ALU_ADD;
        op_d    = OP;
        state_d = decode_op(op_in);
        if (decode_op(op_in) == TRAP) cause_d = TRAP_ILLEGAL;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        alu_op  = ALU_RTYPE;
        state_d = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = imm_aluop(op_cur);
        state_d = ALU_WB;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_cur == R_Type) ? 2'b01 : 2'b00;
        MemtoReg = 2'b00;
        state_d  = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = ALU_ADD;
        state_d = (op_cur == LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          MemRead = 1'b0;
          state_d = TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
        MemtoReg = 2'b01;
        state_d  = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          MemWrite = 1'b0;
          state_d  = TRAP;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        alu_op      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchType  = (op_cur == BEQ);
        state_d     = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        alu_op   = ALU_NOP;
        if (op_cur == JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (!reset) begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchType  = 1'b0;
      PCSource    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      alu_op      = 3'b000;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      RegWrite    = 1'b0;
    end

    ALUOp = ALUOP_WIDTH'(alu_op);
  end

  assign state      = state_q;
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors
// are queued as stimulus is applied and compared at the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OP = 6'h00;
  logic       mem_ready = 1'b1;

  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchType;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg, trap_cause;
  logic       ALUSrcA, RegWrite, trap;
  logic [2:0] ALUOp;
  logic [3:0] state;

  multicycle_control #(
    .OP_WIDTH(6), .ALUOP_WIDTH(3), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchType(BranchType),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [26:0] obs;
  assign obs = {state, trap, trap_cause, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                PCWriteCond, BranchType, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                RegDst, MemtoReg, RegWrite};

  typedef struct {
    string       tag;
    logic [26:0] exp;
  } sb_t;

  sb_t        sbq[$];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_cause = 2'b00;

  // Expected outputs for a state (st < 0 means reset held: everything 0).
  function automatic logic [26:0] exp_for(input int st, input logic [5:0] op,
                                          input logic rdy, input logic to,
                                          input logic [1:0] cause);
    logic iord = 0, mr = 0, mw = 0, irw = 0, pcw = 0, pcwc = 0, bt = 0;
    logic srca = 0, rw = 0, trp = 0;
    logic [1:0] pcs = 0, srcb = 0, rd = 0, m2r = 0;
    logic [2:0] alu = 0;
    logic [3:0] s;
    s = (st < 0) ? 4'd0 : 4'(st);
    case (st)
      0:  begin mr = !to; srcb = 2'b01; alu = 3'b100; irw = rdy; pcw = rdy; end
      1:  begin srcb = 2'b11; alu = 3'b100; end
      2:  begin srca = 1; srcb = 2'b10; alu = 3'b100; end
      3:  begin mr = !to; iord = 1; end
      4:  begin rw = 1; rd = 2'b00; m2r = 2'b01; end
      5:  begin mw = !to; iord = 1; end
      6:  begin srca = 1; srcb = 2'b00; alu = 3'b111; end
      7:  begin
            srca = 1; srcb = 2'b10;
            case (op)
              6'h0D:   alu = 3'b101;
              6'h0C:   alu = 3'b110;
              6'h0F:   alu = 3'b000;
              default: alu = 3'b100;
            endcase
          end
      8:  begin rw = 1; rd = (op == 6'h00) ? 2'b01 : 2'b00; end
      9:  begin srca = 1; alu = 3'b001; pcwc = 1; pcs = 2'b01; bt = (op == 6'h04); end
      10: begin
            pcw = 1; pcs = 2'b10; alu = 3'b010;
            if (op == 6'h03) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
          end
      11: trp = 1;
      default: ;
    endcase
    return {s, trp, cause, iord, mr, mw, irw, pcw, pcwc, bt, pcs, srca, srcb,
            alu, rd, m2r, rw};
  endfunction

  // Pop the oldest expectation and compare against the sampled outputs.
  task automatic check();
    sb_t e;
    e = sbq.pop_front();
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.exp);
    end
  endtask

  // One clock cycle: drive inputs (OP only meaningful in DECODE), queue the
  // expectation, check at the falling edge, return just after the next rise.
  task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                      input int st, input logic to);
    sb_t e;
    OP        = (st == 1) ? op : 6'($urandom);
    mem_ready = rdy;
    e.tag     = tag;
    e.exp     = exp_for(st, op, rdy, to, exp_cause);
    sbq.push_back(e);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold", 6'h00, 1'b1, -1, 1'b0);
    reset = 1'b1;

    // R-type: 0,1,6,8
    step("r_fetch",  6'h00, 1'b1, 0, 1'b0);
    step("r_decode", 6'h00, 1'b1, 1, 1'b0);
    step("r_exec",   6'h00, 1'b1, 6, 1'b0);
    step("r_wb",     6'h00, 1'b1, 8, 1'b0);

    // ORI and LUI immediates
    step("ori_fetch",  6'h0D, 1'b1, 0, 1'b0);
    step("ori_decode", 6'h0D, 1'b1, 1, 1'b0);
    step("ori_exec",   6'h0D, 1'b1, 7, 1'b0);
    step("ori_wb",     6'h0D, 1'b1, 8, 1'b0);
    step("lui_fetch",  6'h0F, 1'b1, 0, 1'b0);
    step("lui_decode", 6'h0F, 1'b1, 1, 1'b0);
    step("lui_exec",   6'h0F, 1'b1, 7, 1'b0);
    step("lui_wb",     6'h0F, 1'b1, 8, 1'b0);

    // LW with two stall cycles in MEM_RD: 7 cycles
    step("lw_fetch",  6'h23, 1'b1, 0, 1'b0);
    step("lw_decode", 6'h23, 1'b1, 1, 1'b0);
    step("lw_addr",   6'h23, 1'b1, 2, 1'b0);
    step("lw_rd0",    6'h23, 1'b0, 3, 1'b0);
    step("lw_rd1",    6'h23, 1'b0, 3, 1'b0);
    step("lw_rd2",    6'h23, 1'b1, 3, 1'b0);
    step("lw_wb",     6'h23, 1'b1, 4, 1'b0);

    // SW with a fetch stall and a write stall
    step("sw_fetch0", 6'h2B, 1'b0, 0, 1'b0);
    step("sw_fetch1", 6'h2B, 1'b1, 0, 1'b0);
    step("sw_decode", 6'h2B, 1'b1, 1, 1'b0);
    step("sw_addr",   6'h2B, 1'b1, 2, 1'b0);
    step("sw_wr0",    6'h2B, 1'b0, 5, 1'b0);
    step("sw_wr1",    6'h2B, 1'b1, 5, 1'b0);

    // Branches and jumps: 3 cycles each
    step("beq_fetch",  6'h04, 1'b1, 0, 1'b0);
    step("beq_decode", 6'h04, 1'b1, 1, 1'b0);
    step("beq_br",     6'h04, 1'b1, 9, 1'b0);
    step("bne_fetch",  6'h05, 1'b1, 0, 1'b0);
    step("bne_decode", 6'h05, 1'b1, 1, 1'b0);
    step("bne_br",     6'h05, 1'b1, 9, 1'b0);
    step("jal_fetch",  6'h03, 1'b1, 0, 1'b0);
    step("jal_decode", 6'h03, 1'b1, 1, 1'b0);
    step("jal_jump",   6'h03, 1'b1, 10, 1'b0);
    step("j_fetch",    6'h02, 1'b1, 0, 1'b0);
    step("j_decode",   6'h02, 1'b1, 1, 1'b0);
    step("j_jump",     6'h02, 1'b1, 10, 1'b0);

    // Reset asserted mid-instruction in MEM_RD
    step("lw2_fetch",  6'h23, 1'b1, 0, 1'b0);
    step("lw2_decode", 6'h23, 1'b1, 1, 1'b0);
    step("lw2_addr",   6'h23, 1'b1, 2, 1'b0);
    step("lw2_rd0",    6'h23, 1'b0, 3, 1'b0);
    reset = 1'b0;
    step("rst_mid",    6'h23, 1'b1, -1, 1'b0);
    reset = 1'b1;

    // Ready arriving exactly at the timeout count wins
    for (int i = 0; i < 4; i++) step("win_stall", 6'h0C, 1'b0, 0, 1'b0);
    step("win_fetch",  6'h0C, 1'b1, 0, 1'b0);
    step("win_decode", 6'h0C, 1'b1, 1, 1'b0);
    step("andi_exec",  6'h0C, 1'b1, 7, 1'b0);
    step("andi_wb",    6'h0C, 1'b1, 8, 1'b0);

    // Illegal opcode: sticky TRAP for 100 cycles
    step("ill_fetch",  6'h3F, 1'b1, 0, 1'b0);
    step("ill_decode", 6'h3F, 1'b1, 1, 1'b0);
    exp_cause = 2'b01;
    for (int i = 0; i < 100; i++) step("ill_trap", 6'h3F, 1'($urandom), 11, 1'b0);

    reset = 1'b0;
    exp_cause = 2'b00;
    step("ill_reset", 6'h00, 1'b1, -1, 1'b0);
    reset = 1'b1;
    step("restart_fetch",  6'h00, 1'b1, 0, 1'b0);
    step("restart_decode", 6'h00, 1'b1, 1, 1'b0);
    step("restart_exec",   6'h00, 1'b1, 6, 1'b0);
    step("restart_wb",     6'h00, 1'b1, 8, 1'b0);

    // Memory timeout in FETCH
    for (int i = 0; i < 4; i++) step("to_stall", 6'h00, 1'b0, 0, 1'b0);
    step("to_expire", 6'h00, 1'b0, 0, 1'b1);
    exp_cause = 2'b10;
    for (int i = 0; i < 5; i++) step("to_trap", 6'h00, 1'($urandom), 11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle MIPS datapath, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and drives the datapath strobes per state. It adds a memory-ready handshake with a watchdog timeout and a sticky trap state for illegal opcodes. It sits between the instruction register's opcode field and the shared datapath muxes, register file and unified memory.

## Interface
- OP_WIDTH, 6, opcode field width
- ALUOP_WIDTH, 3, ALU-control opcode width
- MEM_TIMEOUT, 15, maximum cycles spent waiting for `mem_ready` in any memory state; 0 disables the watchdog

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- OP  in  OP_WIDTH  opcode from the instruction register, sampled in DECODE only
- mem_ready  in  1  memory has completed the current read or write this cycle
- IorD, MemRead, MemWrite, IRWrite  out  1  memory address select, memory strobes, IR load
- PCWrite, PCWriteCond, BranchType  out  1  unconditional PC load, conditional PC load, branch sense (1 = beq, 0 = bne)
- PCSource  out  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- ALUOp  out  ALUOP_WIDTH  operation code to the ALU control block
- RegDst, MemtoReg  out  2  RegDst: 00 = rt, 01 = rd, 10 = $31. MemtoReg: 00 = ALUOut, 01 = MDR, 10 = PC
- RegWrite  out  1  register file write enable
- state  out  4  current state, for debug
- trap  out  1  FSM is halted in TRAP
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout; sticky until reset

## Operation
- States: FETCH(0), DECODE(1), MEM_ADDR(2), MEM_RD(3), MEM_WB(4), MEM_WR(5), EXEC_R(6), EXEC_I(7), ALU_WB(8), BRANCH(9), JUMP(10), TRAP(11).
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
  - IRWrite=PCWrite=`mem_ready`, PCSource=00.
  - Moves to DECODE on `mem_ready`, otherwise holds.
- DECODE:
  - Drives branch-target precompute: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
  - Next state by opcode: 0x00 → EXEC_R; 0x08/0x0D/0x0C/0x0F → EXEC_I; 0x23/0x2B → MEM_ADDR; 0x04/0x05 → BRANCH; 0x02/0x03 → JUMP; any other opcode → TRAP with cause 01.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE → ALU_WB with RegDst=01.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode (ADDI→ADD, ORI→OR, ANDI→AND, LUI→LUI) → ALU_WB with RegDst=00.
- The captured opcode is held in a register from DECODE, so OP is don't-care after DECODE.
- ALU_WB: RegWrite=1, MemtoReg=00 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD → MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Moves to MEM_WB on `mem_ready`.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01 → FETCH.
- MEM_WR: MemWrite=1, IorD=1. Moves to FETCH on `mem_ready`.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, BranchType=1 for beq and 0 for bne → FETCH.
- JUMP:
  - PCWrite=1, PCSource=10, ALUOp=NOP → FETCH.
  - For JAL only: RegWrite=1, RegDst=10, MemtoReg=10.
- TRAP: every strobe is 0 and `trap`=1. Only reset exits TRAP.
- Outputs not listed for a state are 0.
- Watchdog:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle `mem_ready`=0 in those states.
  - When it reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0), the next state is TRAP with cause 10, and the memory strobes drop.
  - `mem_ready` and timeout in the same cycle: `mem_ready` wins.
  - The counter saturates and never wraps.

## Timing
- State, captured opcode, wait counter and trap_cause are registered. All other outputs are decoded combinationally from state; IRWrite and PCWrite in FETCH are additionally gated by `mem_ready`.
- Cycles per instruction with `mem_ready` always 1: R-type/immediate 4, LW 5, SW 4, branch 3, J/JAL 3.
- Each cycle `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle; MemRead/MemWrite stay asserted throughout the wait.
- While `reset`=0: state=FETCH, counter=0, trap_cause=00, and all output strobes forced to 0 (state output reads 0). This holds even mid-instruction; nothing completes.
- The first FETCH strobes appear on the first cycle after `reset` rises.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings and opcode localparams (R_Type, ADDI, ORI, ANDI, LUI, BEQ, BNE, LW, SW, J, JAL);
  - ALUOp codes: ADD=100, SUB=001, RTYPE=111, OR=101, AND=110, LUI=000, NOP=010;
  - trap cause codes.
- The ALUOp codes are the same values the ALU control block already decodes.
- One sub-module, `mem_wait_watchdog`, contains the clear/increment/saturate counter and the timeout flag.

## Test plan
- R-type (OP=0x00), `mem_ready`=1 → states 0,1,6,8,0; RegWrite=1 with RegDst=01 only in cycle 4.
- LW (0x23), `mem_ready`=0 for 2 cycles in MEM_RD → MemRead high for 3 cycles in MEM_RD, then MEM_WB with MemtoReg=01; 7 cycles total.
- BNE (0x05) → 3 cycles; in BRANCH: PCWriteCond=1, BranchType=0, ALUOp=001, PCSource=01.
- JAL (0x03) → in JUMP: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. J (0x02) → same with RegWrite=0.
- OP=0x3F → TRAP, trap_cause=01, all strobes 0 for 100 cycles; after a reset pulse the FSM restarts in FETCH.
- MEM_TIMEOUT=4, `mem_ready` held 0 in FETCH → TRAP with cause 10 after 4 cycles. Separately, reset asserted during MEM_RD → all strobes 0 in the same cycle, FETCH after release.
